// File: rtl/host_arbiter.sv
// host_arbiter: shares the RGB frame-write path between the remote host (1) and the
// local override host (2). Host 2 wins and locks host 1 out for LOCK_MS 1 kHz ticks.
module host_arbiter #(
  parameter logic [15:0] LOCK_MS       = 16'd1000,
  parameter logic [3:0]  SETTLE_CYCLES = 4'd2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLK_1kHz,
  input  logic         REQ_1,
  input  logic [255:0] DATA_1,
  input  logic [7:0]   BANK_1,
  output logic         ACK_1,
  output logic         NAK_1,
  input  logic         REQ_2,
  input  logic [255:0] DATA_2,
  input  logic [7:0]   BANK_2,
  output logic         ACK_2,
  input  logic         BUSY,
  output logic [255:0] DATA,
  output logic [7:0]   BANK,
  output logic         DATA_WRITE_COPY,
  output logic [1:0]   OWNER,
  output logic         LOCK_ACTIVE,
  output logic [7:0]   DROP_CNT_1
);

  localparam int unsigned DATA_W   = 256;
  localparam int unsigned BANK_W   = 8;
  localparam int unsigned LOCK_W   = 16;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_STROBE, ST_SETTLE} state_e;

  state_e              state_q, state_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                tk_s1_q, tk_s1_d, tk_s2_q, tk_s2_d;
  logic                blk_1_q, blk_1_d, blk_2_q, blk_2_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [1:0]          owner_q, owner_d;
  logic                ack_1_q, ack_1_d, nak_1_q, nak_1_d, ack_2_q, ack_2_d;
  logic                wr_q, wr_d, lock_act_q, lock_act_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic tick, arb_en, svc_1, svc_2, grant_1, grant_2, drop_1;

  // A request is serviceable only once its REQ has been seen low since its last ACK.
  assign tick    = tk_s1_q & ~tk_s2_q;
  assign arb_en  = (state_q == ST_IDLE) & ~BUSY;
  assign svc_1   = REQ_1 & ~blk_1_q;
  assign svc_2   = REQ_2 & ~blk_2_q;
  assign grant_2 = arb_en & svc_2;
  assign grant_1 = arb_en & ~svc_2 & svc_1 & (lock_q == '0);
  assign drop_1  = arb_en & ~svc_2 & svc_1 & (lock_q != '0);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_1 | grant_2) state_d = ST_GRANT;
      ST_GRANT:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q <= SETTLE_W'(1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered on the arbitration edge so ACK lands one cycle after the REQ sample.
  always_comb begin
    tk_s1_d    = CLK_1kHz;
    tk_s2_d    = tk_s1_q;
    blk_1_d    = (blk_1_q & REQ_1) | grant_1 | drop_1;
    blk_2_d    = (blk_2_q & REQ_2) | grant_2;
    data_d     = data_q;
    bank_d     = bank_q;
    owner_d    = owner_q;
    ack_1_d    = grant_1 | drop_1;
    nak_1_d    = drop_1;
    ack_2_d    = grant_2;
    wr_d       = (state_q == ST_GRANT);
    drop_d     = drop_q;
    lock_d     = lock_q;
    settle_d   = settle_q;

    if (grant_2) begin
      data_d  = DATA_2;
      bank_d  = BANK_2;
      owner_d = 2'd2;
    end else if (grant_1) begin
      data_d  = DATA_1;
      bank_d  = BANK_1;
      owner_d = 2'd1;
    end

    if (drop_1 && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);

    // A lock load beats a coincident tick.
    if (grant_2)                      lock_d = LOCK_MS;
    else if (tick && (lock_q != '0)) lock_d = lock_q - LOCK_W'(1);

    if (state_q == ST_STROBE)                          settle_d = SETTLE_CYCLES;
    else if ((state_q == ST_SETTLE) && (settle_q != '0)) settle_d = settle_q - SETTLE_W'(1);

    lock_act_d = (lock_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tk_s1_q    <= 1'b0;
      tk_s2_q    <= 1'b0;
      blk_1_q    <= 1'b0;
      blk_2_q    <= 1'b0;
      data_q     <= '0;
      bank_q     <= '0;
      owner_q    <= '0;
      ack_1_q    <= 1'b0;
      nak_1_q    <= 1'b0;
      ack_2_q    <= 1'b0;
      wr_q       <= 1'b0;
      drop_q     <= '0;
      lock_q     <= '0;
      settle_q   <= '0;
      lock_act_q <= 1'b0;
    end else begin
      tk_s1_q    <= tk_s1_d;
      tk_s2_q    <= tk_s2_d;
      blk_1_q    <= blk_1_d;
      blk_2_q    <= blk_2_d;
      data_q     <= data_d;
      bank_q     <= bank_d;
      owner_q    <= owner_d;
      ack_1_q    <= ack_1_d;
      nak_1_q    <= nak_1_d;
      ack_2_q    <= ack_2_d;
      wr_q       <= wr_d;
      drop_q     <= drop_d;
      lock_q     <= lock_d;
      settle_q   <= settle_d;
      lock_act_q <= lock_act_d;
    end
  end

  assign DATA            = data_q;
  assign BANK            = bank_q;
  assign OWNER           = owner_q;
  assign ACK_1           = ack_1_q;
  assign NAK_1           = nak_1_q;
  assign ACK_2           = ack_2_q;
  assign DATA_WRITE_COPY = wr_q;
  assign LOCK_ACTIVE     = lock_act_q;
  assign DROP_CNT_1      = drop_q;

endmodule

// File: tb/tb_host_arbiter.sv
// tb_host_arbiter: directed plan items plus randomized transactions checked against a
// transaction-level model of lockout, drop counting and forwarded frame.
module tb_host_arbiter;

  localparam logic [15:0] LOCK_MS = 16'd3;
  localparam logic [3:0]  SETTLE  = 4'd2;
  localparam int          POST    = int'(SETTLE) + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_1k = 1'b0;
  logic         req_1 = 1'b0, req_2 = 1'b0, busy = 1'b0;
  logic [255:0] data_1 = '0, data_2 = '0, data;
  logic [7:0]   bank_1 = '0, bank_2 = '0, bank;
  logic         ack_1, nak_1, ack_2, wr, lock_active;
  logic [1:0]   owner;
  logic [7:0]   drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference state.
  int           m_lock  = 0;
  int           m_drops = 0;
  logic [255:0] m_data  = '0;
  logic [7:0]   m_bank  = '0;
  logic [1:0]   m_owner = '0;

  always #5 clk = ~clk;

  host_arbiter #(.LOCK_MS(LOCK_MS), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(clk), .RST(rst), .CLK_1kHz(clk_1k),
    .REQ_1(req_1), .DATA_1(data_1), .BANK_1(bank_1), .ACK_1(ack_1), .NAK_1(nak_1),
    .REQ_2(req_2), .DATA_2(data_2), .BANK_2(bank_2), .ACK_2(ack_2),
    .BUSY(busy), .DATA(data), .BANK(bank), .DATA_WRITE_COPY(wr),
    .OWNER(owner), .LOCK_ACTIVE(lock_active), .DROP_CNT_1(drop_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (wr === 1'b1) chk("wr_not_back_to_back", 256'(prev_wr), 256'd0);
    prev_wr <= wr;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      clk_1k = 1'b1;
      cyc(3);
      clk_1k = 1'b0;
      cyc(3);
    end
    m_lock = (m_lock > n) ? m_lock - n : 0;
    chk("lock_active_after_ticks", 256'(lock_active), 256'(m_lock != 0));
  endtask

  task automatic wait_ack(input int host, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while ((((host == 1) ? ack_1 : ack_2) !== 1'b1) && (n < 40));
  endtask

  task automatic check_fwd(input string tag);
    chk({tag, "_data"}, data, m_data);
    chk({tag, "_bank"}, 256'(bank), 256'(m_bank));
    chk({tag, "_owner"}, 256'(owner), 256'(m_owner));
    chk({tag, "_lock_active"}, 256'(lock_active), 256'(m_lock != 0));
    chk({tag, "_nak"}, 256'(nak_1), 256'd0);
    chk({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(m_drops));
    chk({tag, "_wr_at_ack"}, 256'(wr), 256'd0);
  endtask

  task automatic xact(input bit r1, input bit r2,
                      input logic [255:0] d1, input logic [7:0] b1,
                      input logic [255:0] d2, input logic [7:0] b2,
                      input int busy_cyc, input int hold);
    int n;
    data_1 = d1; bank_1 = b1; data_2 = d2; bank_2 = b2;
    busy  = (busy_cyc > 0);
    req_1 = r1;
    req_2 = r2;
    for (int i = 0; i < busy_cyc; i++) begin
      cyc(1);
      chk("busy_blocks", 256'({ack_1, ack_2, wr}), 256'd0);
    end
    busy = 1'b0;
    if (r2) begin
      wait_ack(2, n);
      chk("ack2_latency", 256'(n), 256'd1);
      m_data = d2; m_bank = b2; m_owner = 2'd2; m_lock = int'(LOCK_MS);
      check_fwd("h2");
      for (int i = 1; i <= POST; i++) begin
        if (i > hold) req_2 = 1'b0;
        cyc(1);
        chk("h2_strobe", 256'(wr), 256'(i == 1));
        chk("h2_no_reack", 256'({ack_1, ack_2}), 256'd0);
      end
      req_2 = 1'b0;
    end
    if (r1) begin
      wait_ack(1, n);
      chk("ack1_latency", 256'(n), 256'd1);
      if (m_lock > 0) begin
        if (m_drops < 255) m_drops++;
        chk("drop_nak", 256'(nak_1), 256'd1);
        chk("drop_cnt", 256'(drop_cnt), 256'(m_drops));
        chk("drop_data", data, m_data);
        chk("drop_bank", 256'(bank), 256'(m_bank));
        chk("drop_owner", 256'(owner), 256'(m_owner));
        for (int i = 1; i <= 3; i++) begin
          if (i > hold) req_1 = 1'b0;
          cyc(1);
          chk("drop_quiet", 256'({ack_1, nak_1, wr}), 256'd0);
        end
      end else begin
        m_data = d1; m_bank = b1; m_owner = 2'd1;
        check_fwd("h1");
        for (int i = 1; i <= POST; i++) begin
          if (i > hold) req_1 = 1'b0;
          cyc(1);
          chk("h1_strobe", 256'(wr), 256'(i == 1));
          chk("h1_no_reack", 256'({ack_1, ack_2}), 256'd0);
        end
      end
      req_1 = 1'b0;
    end
    cyc(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, data, 256'd0);
    chk({tag, "_ctl"}, 256'({bank, owner, ack_1, nak_1, ack_2, wr, lock_active, drop_cnt}), 256'd0);
  endtask

  initial begin
    logic [255:0] pat;
    int sel;
    pat = {32{8'hA5}};

    cyc(2);
    check_all_zero("reset");
    rst = 1'b0;
    cyc(2);

    // First host-1 frame, nothing locked.
    xact(1'b1, 1'b0, pat, 8'h03, '0, 8'h00, 0, 0);
    chk("first_data", data, pat);
    chk("first_bank", 256'(bank), 256'h03);

    // Both at once: host 2 first, host 1 dropped by the fresh lock.
    xact(1'b1, 1'b1, r256(), 8'h01, r256(), 8'h02, 0, 0);
    chk("both_bank", 256'(bank), 256'h02);
    chk("both_drop_cnt", 256'(drop_cnt), 256'd1);

    // Lock expires exactly after the third tick.
    tick_n(2);
    chk("lock_still_on", 256'(lock_active), 256'd1);
    tick_n(1);
    chk("lock_released", 256'(lock_active), 256'd0);
    xact(1'b1, 1'b0, r256(), 8'h11, '0, 8'h00, 0, 0);

    // Long BUSY stall on host 2.
    xact(1'b0, 1'b1, '0, 8'h00, r256(), 8'h22, 50, 0);

    // Drop counter saturation under a held lock.
    for (int k = 0; k < 300; k++)
      xact(1'b1, 1'b0, r256(), 8'($urandom), '0, 8'h00, 0, int'($urandom_range(0, 2)));
    chk("drop_saturated", 256'(drop_cnt), 256'd255);

    // Reset landing in the GRANT cycle aborts the transfer.
    data_2 = r256();
    bank_2 = 8'h5A;
    req_2  = 1'b1;
    cyc(1);
    chk("grant_before_rst", 256'(ack_2), 256'd1);
    rst   = 1'b1;
    req_2 = 1'b0;
    cyc(1);
    check_all_zero("rst_in_grant");
    rst = 1'b0;
    m_lock = 0; m_drops = 0; m_data = '0; m_bank = '0; m_owner = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("post_rst_no_strobe", 256'({wr, ack_2, lock_active}), 256'd0);
    end

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      tick_n(int'($urandom_range(0, 4)));
      sel = int'($urandom_range(1, 3));
      xact(sel[0], sel[1], r256(), 8'($urandom), r256(), 8'($urandom),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
